// File: rtl/burst_mem_ctrl.sv
// Single-port word memory with EEPROM-style burst access: START loads the pointer,
// strobes move one word each, STOP closes. Page-wrapped writes, array-rolling reads.
module burst_mem_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 7,
    parameter int DEPTH        = 128,
    parameter int PAGE_SIZE    = 8,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              rw_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_stb_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              rd_stb_i,
    input  logic              wp_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              rd_valid_o,
    output logic              wp_err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ptr_o
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PMASK_C = ADDR_W'(PAGE_SIZE - 1);
    localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] clr_q;
    logic [DATA_W-1:0] dout_q;
    logic              rdv_q;
    logic              wperr_q;
    logic              busy_q;

    logic              beat_ok_d;
    logic              wr_beat_d;
    logic              rd_beat_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [ADDR_W-1:0] ptr_page_d;
    logic [ADDR_W-1:0] ptr_roll_d;
    logic [ADDR_W-1:0] ptr_load_d;

    // A strobe survives STOP (performed before closing) but is dropped by a restart.
    always_comb begin
        beat_ok_d   = stop_i | ~start_i;
        wr_beat_d   = rst_n_i && (state_q == S_WRITE) && wr_stb_i && beat_ok_d;
        rd_beat_d   = rst_n_i && (state_q == S_READ) && rd_stb_i && beat_ok_d;
        mem_we_d    = (rst_n_i && (state_q == S_INIT)) || (wr_beat_d && !wp_i);
        mem_addr_d  = (state_q == S_INIT) ? clr_q : ptr_q;
        mem_wdata_d = (state_q == S_INIT) ? '0 : data_in_i;
        ptr_page_d  = (ptr_q & ~PMASK_C) | ((ptr_q + ONE_C) & PMASK_C);
        ptr_roll_d  = (ptr_q == LAST_C) ? '0 : ptr_q + ONE_C;
        ptr_load_d  = ({1'b0, addr_i} >= DEPTH_C) ? '0 : addr_i;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR_ON_RST ? S_INIT : S_IDLE;
            busy_q  <= CLEAR_ON_RST;
            ptr_q   <= '0;
            clr_q   <= '0;
            dout_q  <= '0;
            rdv_q   <= 1'b0;
            wperr_q <= 1'b0;
        end else begin
            rdv_q   <= 1'b0;
            wperr_q <= 1'b0;
            if (wr_beat_d) begin
                ptr_q   <= ptr_page_d;
                wperr_q <= wp_i;
            end
            if (rd_beat_d) begin
                dout_q <= mem_q[ptr_q];
                rdv_q  <= 1'b1;
                ptr_q  <= ptr_roll_d;
            end
            case (state_q)
                S_INIT: begin
                    clr_q <= clr_q + ONE_C;
                    if (clr_q == LAST_C) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        ptr_q   <= ptr_load_d;
                        state_q <= rw_i ? S_WRITE : S_READ;
                    end
                end
                default: begin
                    if (stop_i) begin
                        state_q <= S_IDLE;
                    end else if (start_i) begin
                        ptr_q   <= ptr_load_d;
                        state_q <= rw_i ? S_WRITE : S_READ;
                    end
                end
            endcase
        end
    end

    assign data_out_o = dout_q;
    assign rd_valid_o = rdv_q;
    assign wp_err_o   = wperr_q;
    assign busy_o     = busy_q;
    assign ptr_o      = ptr_q;

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Bench for burst_mem_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against an array-based transaction model.
module tb_burst_mem_ctrl;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 7;
    localparam int DEPTH     = 128;
    localparam int PAGE_SIZE = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, stop = 1'b0, rw = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              wr_stb = 1'b0, rd_stb = 1'b0, wp = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid, wp_err, busy;
    logic [ADDR_W-1:0] ptr;

    burst_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .PAGE_SIZE(PAGE_SIZE), .CLEAR_ON_RST(1'b1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .rw_i(rw),
        .addr_i(addr), .wr_stb_i(wr_stb), .data_in_i(data_in), .rd_stb_i(rd_stb),
        .wp_i(wp), .data_out_o(data_out), .rd_valid_o(rd_valid), .wp_err_o(wp_err),
        .busy_o(busy), .ptr_o(ptr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction model: mode 0 idle, 1 write burst, 2 read burst.
    int m_mem [DEPTH];
    int m_ptr, m_mode, m_busy, m_dout;
    bit m_rv, m_we;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit beat;
        if (!rst_n) begin
            m_ptr = 0; m_dout = 0; m_rv = 0; m_we = 0; m_mode = 0;
            m_busy = DEPTH;
            return;
        end
        m_rv = 0;
        m_we = 0;
        if (m_busy > 0) begin
            m_mem[DEPTH - m_busy] = 0;
            m_busy--;
            return;
        end
        beat = stop || !start;
        if (m_mode == 1 && wr_stb && beat) begin
            if (wp) m_we = 1;
            else    m_mem[m_ptr] = int'(data_in);
            m_ptr = (m_ptr / PAGE_SIZE) * PAGE_SIZE + (m_ptr + 1) % PAGE_SIZE;
        end
        if (m_mode == 2 && rd_stb && beat) begin
            m_dout = m_mem[m_ptr];
            m_rv   = 1;
            m_ptr  = (m_ptr + 1) % DEPTH;
        end
        if (stop) begin
            m_mode = 0;
        end else if (start) begin
            m_ptr  = (int'(addr) < DEPTH) ? int'(addr) : 0;
            m_mode = rw ? 1 : 2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ptr", int'(ptr), m_ptr);
        chk("busy", int'(busy), (m_busy > 0) ? 1 : 0);
        chk("rd_valid", int'(rd_valid), int'(m_rv));
        chk("wp_err", int'(wp_err), int'(m_we));
        chk("data_out", int'(data_out), m_dout);
    endtask

    task automatic quiet();
        start = 0; stop = 0; wr_stb = 0; rd_stb = 0;
    endtask

    task automatic open_burst(input bit dir, input int a);
        quiet();
        start = 1; rw = dir; addr = ADDR_W'(a);
        tick();
        start = 0;
    endtask

    task automatic close_burst();
        quiet();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic write_beat(input int d);
        wr_stb = 1; data_in = DATA_W'(d);
        tick();
        wr_stb = 0;
    endtask

    task automatic read_at(input int a, output int d);
        open_burst(1'b0, a);
        rd_stb = 1;
        tick();
        rd_stb = 0;
        d = int'(data_out);
        close_burst();
    endtask

    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (busy && cycles < 300) begin
            cycles++;
            tick();
        end
        if (cycles >= 300) chk("sweep_timeout", cycles, DEPTH);
    endtask

    initial begin
        int d, cyc;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        // Power-up reset and initial sweep
        rst_n = 0;
        tick();
        chk("rst_ptr", int'(ptr), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_dout", int'(data_out), 0);
        rst_n = 1;
        wait_sweep(cyc);

        // 1: write 0xAA at 0x10, reset pulse, sweep length, all words zero
        open_burst(1'b1, 'h10);
        write_beat('hAA);
        close_burst();
        read_at('h10, d);
        chk("t1_pre", d, 'hAA);
        rst_n = 0;
        tick();
        rst_n = 1;
        wait_sweep(cyc);
        chk("t1_busy_len", cyc, 128);
        open_burst(1'b0, 0);
        rd_stb = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("t1_zero", int'(data_out), 0);
        end
        rd_stb = 0;
        close_burst();

        // 2: page-wrapped write burst
        wp = 0;
        open_burst(1'b1, 'h05);
        for (int i = 0; i < 5; i++) write_beat('hA0 + i);
        chk("t2_ptr", int'(ptr), 'h02);
        close_burst();
        read_at('h05, d); chk("t2_m5", d, 'hA0);
        read_at('h07, d); chk("t2_m7", d, 'hA2);
        read_at('h00, d); chk("t2_m0", d, 'hA3);
        read_at('h01, d); chk("t2_m1", d, 'hA4);
        read_at('h08, d); chk("t2_m8", d, 'h00);

        // 3: read burst rolls over the array end
        open_burst(1'b0, 'h7E);
        rd_stb = 1;
        tick(); chk("t3_v0", int'(rd_valid), 1); chk("t3_d0", int'(data_out), 'h00);
        tick(); chk("t3_v1", int'(rd_valid), 1); chk("t3_d1", int'(data_out), 'h00);
        tick(); chk("t3_v2", int'(rd_valid), 1); chk("t3_d2", int'(data_out), 'hA3);
        rd_stb = 0;
        tick(); chk("t3_pulse", int'(rd_valid), 0);
        chk("t3_ptr", int'(ptr), 'h01);
        close_burst();

        // 4: write protect rejects the beat but advances the pointer
        open_burst(1'b1, 'h20);
        wp = 1;
        write_beat('h55);
        chk("t4_err", int'(wp_err), 1);
        chk("t4_ptr", int'(ptr), 'h21);
        tick();
        chk("t4_pulse", int'(wp_err), 0);
        wp = 0;
        close_burst();
        read_at('h20, d); chk("t4_mem", d, 'h00);

        // 5: repeated start discards coincident read strobe
        open_burst(1'b0, 'h10);
        start = 1; rw = 1; addr = 'h40; rd_stb = 1;
        tick();
        quiet();
        chk("t5_norv", int'(rd_valid), 0);
        chk("t5_ptr", int'(ptr), 'h40);
        write_beat('h77);
        chk("t5_wmode", int'(ptr), 'h41);
        close_burst();
        read_at('h40, d); chk("t5_mem", d, 'h77);

        // 6: reset aborts a write burst; the coincident beat is lost
        open_burst(1'b1, 'h30);
        for (int i = 0; i < 3; i++) write_beat('h11 + i);
        chk("t6_ptr", int'(ptr), 'h33);
        wr_stb = 1; data_in = 'h99; rst_n = 0;
        tick();
        quiet();
        rst_n = 1;
        chk("t6_busy", int'(busy), 1);
        wait_sweep(cyc);
        read_at('h33, d); chk("t6_mem", d, 'h00);

        // STOP and START together: STOP wins, strobe still performed
        open_burst(1'b1, 'h50);
        start = 1; stop = 1; rw = 0; addr = 'h10; wr_stb = 1; data_in = 'h3C;
        tick();
        quiet();
        chk("ss_ptr", int'(ptr), 'h51);
        read_at('h50, d); chk("ss_mem", d, 'h3C);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 999) != 0);
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 9) == 0);
            rw      = 1'($urandom_range(0, 1));
            addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_stb  = 1'($urandom_range(0, 1));
            rd_stb  = 1'($urandom_range(0, 1));
            wp      = ($urandom_range(0, 3) == 0);
            data_in = DATA_W'($urandom);
            tick();
        end
        rst_n = 1;
        quiet();
        wait_sweep(cyc);
        for (int a = 0; a < DEPTH; a += 9) begin
            read_at(a, d);
            chk("final_mem", d, m_mem[a]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
